// File: rtl/counter.sv
// Free-running binary up counter with programmable terminal count.
// q counts 0..MAX_VALUE and then returns to 0. tc is decoded from q, so it
// is high for the whole cycle in which q == MAX_VALUE. wrap is a registered
// pulse that is high for the one cycle after q goes from MAX_VALUE to 0.
// reset is asynchronous and active-low. The port is named reset rather than
// rst_n so that existing positional instantiations still connect.
module counter #(
  parameter int WIDTH     = 7,
  parameter int MAX_VALUE = (2 ** WIDTH) - 1
) (
  input  logic             reset,
  input  logic             clk,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] LP_MAX = MAX_VALUE[WIDTH-1:0];
  localparam logic [WIDTH-1:0] LP_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic             w_at_max;
  logic [WIDTH-1:0] w_q_next;

  assign w_at_max = (r_q == LP_MAX);

  // Next count: return to zero after the terminal count, otherwise increment.
  always_comb begin
    w_q_next = r_q + LP_ONE;
    if (w_at_max) begin
      w_q_next = '0;
    end
  end

  // Count and wrap registers. Reset clears both at once and never raises wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_q    <= w_q_next;
      r_wrap <= w_at_max;
    end
  end

  assign q    = r_q;
  assign tc   = w_at_max;
  assign wrap = r_wrap;

endmodule

// File: tb/tb_counter.sv
// Bench for counter. It drives two instances: the default one (7 bits,
// terminal count 127) and a small one (4 bits, terminal count 9).
// The checks are, in order: a directed table, hand-written corner sequences,
// and random resets compared against an edge-count model.
module tb_counter;

  localparam int MA = 127;
  localparam int MB = 9;

  logic       clk;
  logic       reset_a;
  logic       reset_b;
  logic [6:0] q_a;
  logic       tc_a;
  logic       wrap_a;
  logic [3:0] q_b;
  logic       tc_b;
  logic       wrap_b;

  int n_tests = 0;
  int n_fail  = 0;
  int n_a     = 0;
  int n_b     = 0;
  int wraps_b = 0;

  counter dut_a (
    .reset (reset_a),
    .clk   (clk),
    .q     (q_a),
    .tc    (tc_a),
    .wrap  (wrap_a)
  );

  counter #(.WIDTH(4), .MAX_VALUE(MB)) dut_b (
    .reset (reset_b),
    .clk   (clk),
    .q     (q_b),
    .tc    (tc_b),
    .wrap  (wrap_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string name;
    bit    rst;
    int    edges;
    int    q;
    bit    tc;
    bit    wrap;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // The model is driven by the number of counting edges since the last reset.
  task automatic check_model(input string tag, input int n, input int m,
                             input int q, input logic tc, input logic wrap);
    int eq;
    eq = n % (m + 1);
    chk({tag, " q"}, q, eq);
    chk({tag, " tc"}, int'(tc), (eq == m) ? 1 : 0);
    chk({tag, " wrap"}, int'(wrap), (n > 0 && eq == 0) ? 1 : 0);
  endtask

  task automatic check_a(input string tag, input int q, input bit tc, input bit wrap);
    chk({tag, " q"}, int'(q_a), q);
    chk({tag, " tc"}, int'(tc_a), int'(tc));
    chk({tag, " wrap"}, int'(wrap_a), int'(wrap));
  endtask

  initial begin
    reset_a = 1'b0;
    reset_b = 1'b0;

    vecs[0] = '{"rst_before_edge", 1'b0, 0,   0,   1'b0, 1'b0};
    vecs[1] = '{"rst_held_2",      1'b0, 2,   0,   1'b0, 1'b0};
    vecs[2] = '{"first_count",     1'b1, 1,   1,   1'b0, 1'b0};
    vecs[3] = '{"count_5",         1'b1, 4,   5,   1'b0, 1'b0};
    vecs[4] = '{"at_max",          1'b1, 122, 127, 1'b1, 1'b0};
    vecs[5] = '{"wrap_to_0",       1'b1, 1,   0,   1'b0, 1'b1};
    vecs[6] = '{"after_wrap",      1'b1, 1,   1,   1'b0, 1'b0};

    #1;
    for (int i = 0; i < 7; i++) begin
      reset_a = vecs[i].rst;
      #1;
      for (int e = 0; e < vecs[i].edges; e++) step();
      check_a(vecs[i].name, vecs[i].q, vecs[i].tc, vecs[i].wrap);
    end

    // Asynchronous clear in the middle of a cycle at q = 60.
    repeat (59) step();
    check_a("pre_async_60", 60, 1'b0, 1'b0);
    #2 reset_a = 1'b0;
    #1;
    check_a("async_clear_60", 0, 1'b0, 1'b0);
    reset_a = 1'b1;
    step();
    check_a("resume_1", 1, 1'b0, 1'b0);
    step();
    check_a("resume_2", 2, 1'b0, 1'b0);

    // Reset applied while sitting on the terminal count must not produce wrap.
    repeat (125) step();
    check_a("pre_rst_max", 127, 1'b1, 1'b0);
    reset_a = 1'b0;
    #1;
    check_a("rst_at_max", 0, 1'b0, 1'b0);
    step();
    check_a("rst_at_max_held", 0, 1'b0, 1'b0);
    reset_a = 1'b1;
    step();
    check_a("rst_at_max_release", 1, 1'b0, 1'b0);

    // Small instance: exact sequence 0..9, then count wrap pulses over 30 edges.
    #1;
    chk("b_rst q", int'(q_b), 0);
    reset_b = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      step();
      chk("b_seq q", int'(q_b), i % 10);
      chk("b_seq tc", int'(tc_b), (i % 10 == 9) ? 1 : 0);
      if (wrap_b) wraps_b++;
    end
    chk("b_wrap_count", wraps_b, 3);

    // Random resets on both instances, each compared against the edge-count model.
    reset_a = 1'b0;
    reset_b = 1'b0;
    #1;
    n_a = 0;
    n_b = 0;
    for (int i = 0; i < 3000; i++) begin
      reset_a = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      reset_b = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
      #1;
      if (!reset_a) n_a = 0;
      if (!reset_b) n_b = 0;
      check_model("rnd_a_mid", n_a, MA, int'(q_a), tc_a, wrap_a);
      check_model("rnd_b_mid", n_b, MB, int'(q_b), tc_b, wrap_b);
      step();
      if (reset_a) n_a++;
      if (reset_b) n_b++;
      check_model("rnd_a", n_a, MA, int'(q_a), tc_a, wrap_a);
      check_model("rnd_b", n_b, MB, int'(q_b), tc_b, wrap_b);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
